load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Bridges the core's data-memory access (load/store) to a handshaked, word-addressed data memory.
// - Produces the load read_data that feeds the writeback result select (result_src = 01).
// - Stores: builds byte strobes and lane-replicated write data.
// - Loads: extracts the byte/half/word and sign- or zero-extends it per RV32I funct3.
// - Holds the core via stall while a transaction is outstanding.
// PARAMETERS
// - WIDTH    32  data width (fixed at 32 for RV32I; strobe logic assumes 4 byte lanes)
// - TIMEOUT  16  max cycles in REQ without mem_ready before aborting with err (>=2)
// PORTS
// - clk          in   1      rising-edge clock
// - rst_n        in   1      asynchronous reset, active-low
// - mem_read     in   1      core requests load (from control unit)
// - mem_write    in   1      core requests store (from control unit)
// - funct3       in   3      RV32I width/sign field of the instruction
// - addr         in   WIDTH  byte address (ALU_result)
// - write_data   in   WIDTH  store data (rs2)
// - read_data    out  WIDTH  extended load data to writeback
// - done         out  1      one-cycle pulse: transaction complete, read_data/err valid
// - err          out  1      with done: misaligned, illegal funct3 or timeout
// - stall        out  1      core must hold PC/inputs while high
// - mem_req      out  1      memory request valid
// - mem_we       out  1      1 = write, 0 = read
// - mem_addr     out  WIDTH  word address {addr[31:2],2'b00}
// - mem_wdata    out  WIDTH  lane-replicated store data
// - mem_wstrb    out  4      byte-lane write strobes (0000 on reads)
// - mem_ready    in   1      memory accepts/completes current request this cycle
// - mem_rdata    in   WIDTH  read word, valid when mem_ready && !mem_we
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, done, err = 0; mem_addr, mem_wdata,
//   read_data = 0; mem_wstrb = 0; stall forced 0.
//   Reset mid-transaction drops mem_req immediately; no completion is reported.
// - FSM states: IDLE, REQ, DONE.
// - IDLE:
//   - start = mem_read | mem_write; mem_read wins if both are high (treated as load).
//   - stall = start (combinational), so the core freezes in the same cycle.
//   - On start with legal funct3 and aligned addr: latch addr, funct3, we, wstrb, wdata;
//     clear timeout count; -> REQ.
//   - On start that is illegal or misaligned: no memory access; set err=1; -> DONE.
//   - Legal funct3, load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
//   - Legal funct3, store: 000 SB, 001 SH, 010 SW.
//   - Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
// - REQ:
//   - mem_req=1; mem_we, mem_addr, mem_wdata, mem_wstrb held stable until mem_ready; stall=1.
//   - If mem_ready: on a load, capture the extended mem_rdata into read_data; -> DONE.
//   - Else count++; when count reaches TIMEOUT-1 without mem_ready: err=1, read_data=0,
//     mem_req drops; -> DONE.
// - DONE: done=1 for exactly one cycle; stall=0; start ignored this cycle; -> IDLE.
//   read_data and err hold until the next transaction latches.
// - Latency: start seen at cycle T; REQ at T+1; mem_ready at T+1+k (k>=0); done at T+2+k.
//   Minimum 3 cycles.
// - Store strobes/data:
//   - SB: wstrb = 0001 << addr[1:0]; wdata = {4{wd[7:0]}}.
//   - SH: wstrb = 0011 << {addr[1],1'b0}; wdata = {2{wd[15:0]}}.
//   - SW: wstrb = 1111; wdata = wd.
// - Load extract:
//   - byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
//   - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
// - Store completion leaves read_data unchanged (result_src never selects it for stores).
// TESTING
// - LB addr 0x103, mem_rdata 0x80FF1234, ready after 0 waits: mem_addr 0x100, wstrb 0000,
//   read_data 0xFFFFFF80; done at T+2.
// - LBU same stimulus: read_data 0x00000080.
// - LH addr 0x102 on 0x80FF1234: read_data 0xFFFF80FF.
// - SH addr 0x202, write_data 0x1234ABCD, ready after 3 waits: mem_we=1, mem_addr 0x200,
//   wstrb 1100, wdata 0xABCDABCD held 4 cycles; done at T+5.
// - LW addr 0x101: mem_req never rises; stall=1 only in cycle T; done=1 and err=1 at T+1.
//   Repeat for funct3=011: same response.
// - TIMEOUT=8, mem_ready held 0: mem_req high for 8 cycles, then done=1, err=1, read_data=0.
//   Separately, rst_n pulsed low mid-REQ: mem_req, stall, done go 0 asynchronously; FSM in
//   IDLE after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store bridge from the core to a word-addressed, ready-handshaked data memory.
// Latency: done two cycles after start plus memory wait cycles; stall holds the core until done.
module load_store_unit #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] write_data,
   output logic [WIDTH-1:0] read_data,
   output logic             done,
   output logic             err,
   output logic             stall,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic             mem_ready,
   input  logic [WIDTH-1:0] mem_rdata
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] maddr_q, maddr_d;
   logic [1:0]       off_q, off_d;
   logic [2:0]       f3_q, f3_d;
   logic             we_q, we_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;

   logic             start;
   logic             is_store;
   logic             legal;
   logic             aligned;
   logic [3:0]       strb_c;
   logic [WIDTH-1:0] wrep_c;
   logic [7:0]       byte_c;
   logic [15:0]      half_c;
   logic [WIDTH-1:0] ext_c;

   assign start    = mem_read | mem_write;
   assign is_store = mem_write & ~mem_read;

   always_comb begin
      legal = 1'b0;
      if (is_store) begin
         legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end else begin
         legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      case (funct3[1:0])
         2'b01:   aligned = ~addr[0];
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      case (funct3[1:0])
         2'b00: begin
            strb_c = 4'b0001 << addr[1:0];
            wrep_c = {4{write_data[7:0]}};
         end
         2'b01: begin
            strb_c = 4'b0011 << {addr[1], 1'b0};
            wrep_c = {2{write_data[15:0]}};
         end
         default: begin
            strb_c = 4'b1111;
            wrep_c = write_data;
         end
      endcase
   end

   always_comb begin
      case (off_q)
         2'b00:   byte_c = mem_rdata[7:0];
         2'b01:   byte_c = mem_rdata[15:8];
         2'b10:   byte_c = mem_rdata[23:16];
         default: byte_c = mem_rdata[31:24];
      endcase
      half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
         3'b100:  ext_c = {24'd0, byte_c};
         3'b001:  ext_c = {{16{half_c[15]}}, half_c};
         3'b101:  ext_c = {16'd0, half_c};
         default: ext_c = mem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      maddr_d = maddr_q;
      off_d   = off_q;
      f3_d    = f3_q;
      we_d    = we_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (legal && aligned) begin
                  maddr_d = {addr[WIDTH-1:2], 2'b00};
                  off_d   = addr[1:0];
                  f3_d    = funct3;
                  we_d    = is_store;
                  wstrb_d = is_store ? strb_c : 4'b0000;
                  wdata_d = wrep_c;
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  state_d = REQ;
               end else begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         REQ: begin
            if (mem_ready) begin
               if (!we_q) rdata_d = ext_c;
               state_d = DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         maddr_q <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         we_q    <= 1'b0;
         wstrb_q <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         maddr_q <= maddr_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         we_q    <= we_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Reset gates stall so a held request cannot freeze the core while rst_n is low.
   assign stall     = rst_n & (((state_q == IDLE) & start) | (state_q == REQ));
   assign mem_req   = (state_q == REQ);
   assign done      = (state_q == DONE);
   assign err       = err_q;
   assign read_data = rdata_q;
   assign mem_we    = we_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit, plus timeout and mid-transaction reset sequences.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0, write_data = '0;
   logic [31:0] read_data;
   logic        done, err, stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int failures = 0;

   load_store_unit #(.WIDTH(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .write_data(write_data), .read_data(read_data),
      .done(done), .err(err), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      int          waits;
      logic        exp_err;
      logic [31:0] exp_rd;
      logic [31:0] exp_maddr;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_wdata;
   } vec_t;

   localparam int NV = 16;
   vec_t vt [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int  n;
      int  reqc;
      bit  got;
      string tag;
      tag = $sformatf("v%0d", idx);
      mem_read   = v.rd;
      mem_write  = v.wr;
      funct3     = v.f3;
      addr       = v.addr;
      write_data = v.wd;
      mem_ready  = 1'b0;
      mem_rdata  = 32'hBAD0BAD0;
      #1;
      chk({tag, "_stall_start"}, {31'd0, stall}, 32'd1);
      n = 0; reqc = 0; got = 0;
      while (!got && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         mem_ready = 1'b0;
         mem_rdata = 32'hBAD0BAD0;
         if (done) begin
            got = 1;
         end else begin
            chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
            chk({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
            chk({tag, "_mem_addr"}, mem_addr, v.exp_maddr);
            chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, v.wr & ~v.rd});
            chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, v.exp_wstrb});
            if (v.wr && !v.rd) chk({tag, "_mem_wdata"}, mem_wdata, v.exp_wdata);
            if (reqc == v.waits) begin
               mem_ready = 1'b1;
               mem_rdata = v.rdata;
            end
            reqc++;
         end
      end
      if (!got) begin
         chk({tag, "_done_seen"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_done_cycle"}, n, v.exp_err ? 32'd1 : 32'(2 + v.waits));
         chk({tag, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
         chk({tag, "_read_data"}, read_data, v.exp_rd);
         chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
         chk({tag, "_req_in_done"}, {31'd0, mem_req}, 32'd0);
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_idle_req"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_hold_read_data"}, read_data, v.exp_rd);
      chk({tag, "_hold_err"}, {31'd0, err}, {31'd0, v.exp_err});
   endtask

   initial begin
      int n;
      int reqc;
      //         rd wr f3      addr          wd            rdata         w  err exp_rd        maddr         strb     wdata
      vt[0]  = '{1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 32'h0000_0100, 4'b0000, 32'h0};
      vt[1]  = '{1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0080, 32'h0000_0100, 4'b0000, 32'h0};
      vt[2]  = '{1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_1234, 0, 0, 32'hFFFF_80FF, 32'h0000_0100, 4'b0000, 32'h0};
      vt[3]  = '{0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        3, 0, 32'hFFFF_80FF, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD};
      vt[4]  = '{1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 32'hFFFF_80FF, 32'h0,        4'b0000, 32'h0};
      vt[5]  = '{1, 0, 3'b011, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 32'hFFFF_80FF, 32'h0,        4'b0000, 32'h0};
      vt[6]  = '{1, 0, 3'b010, 32'h0000_0204, 32'h0,        32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 32'h0000_0204, 4'b0000, 32'h0};
      vt[7]  = '{0, 1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,        0, 0, 32'hDEAD_BEEF, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5};
      vt[8]  = '{0, 1, 3'b010, 32'h0000_040C, 32'h1122_3344, 32'h0,        2, 0, 32'hDEAD_BEEF, 32'h0000_040C, 4'b1111, 32'h1122_3344};
      vt[9]  = '{1, 0, 3'b101, 32'h0000_0106, 32'h0,        32'h8001_7FFE, 0, 0, 32'h0000_8001, 32'h0000_0104, 4'b0000, 32'h0};
      vt[10] = '{1, 0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_007F, 0, 0, 32'h0000_007F, 32'h0000_0100, 4'b0000, 32'h0};
      vt[11] = '{1, 1, 3'b010, 32'h0000_0500, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0, 32'h1234_5678, 32'h0000_0500, 4'b0000, 32'h0};
      vt[12] = '{0, 1, 3'b100, 32'h0000_0600, 32'h0,        32'h0,        0, 1, 32'h1234_5678, 32'h0,        4'b0000, 32'h0};
      vt[13] = '{0, 1, 3'b001, 32'h0000_0201, 32'h0,        32'h0,        0, 1, 32'h1234_5678, 32'h0,        4'b0000, 32'h0};
      vt[14] = '{1, 0, 3'b001, 32'h0000_0100, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_1234, 32'h0000_0100, 4'b0000, 32'h0};
      vt[15] = '{0, 1, 3'b000, 32'h0000_0003, 32'h0000_0077, 32'h0,        0, 0, 32'h0000_1234, 32'h0000_0000, 4'b1000, 32'h7777_7777};

      #2;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
      chk("rst_read_data", read_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) run_vec(i, vt[i]);

      // Timeout: memory never answers, request must abort after 8 REQ cycles.
      mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0700;
      mem_ready = 1'b0;
      n = 0; reqc = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (mem_req) reqc++;
      end
      chk("to_req_cycles", reqc, 32'd8);
      chk("to_done", {31'd0, done}, 32'd1);
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_read_data", read_data, 32'd0);
      mem_read = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of a request.
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0800;
      @(negedge clk);
      @(negedge clk);
      chk("ar_req_before", {31'd0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_req_async", {31'd0, mem_req}, 32'd0);
      chk("ar_stall_async", {31'd0, stall}, 32'd0);
      chk("ar_done_async", {31'd0, done}, 32'd0);
      mem_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ar_no_done", {31'd0, done}, 32'd0);
         chk("ar_no_req", {31'd0, mem_req}, 32'd0);
      end
      run_vec(99, vt[6]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
